pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Consumer-side controller for the system PLL's `rst`/`locked` interface.
- Runs on the reference clock domain.
- Drives PLL reset, waits for lock, and qualifies lock as stable before releasing the system reset to the core.
- Re-sequences on lock loss or lock timeout, and counts retries for debug.

Parameters:
- RST_CYCLES, 16: cycles `pll_rst` is held high per attempt (≥1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before retry (≥1).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release (≥1).
- CNT_W, 20: width of the shared down-counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clk, input, 1: reference clock (same clock that feeds the PLL refclk).
- reset, input, 1: synchronous, active-high; restarts the whole sequence.
- pll_locked, input, 1: PLL `locked`, asynchronous to clk.
- pll_rst, output, 1: drives PLL `rst`.
- sys_reset, output, 1: registered system reset to core logic, active-high.
- pll_ready, output, 1: high only in RUN.
- retry_count, output, 8: saturating count of timeouts plus lock losses.
- state_dbg, output, 2: current state encoding.

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- On reset (and the cycle after it deasserts, until the FSM advances):
  - pll_rst=1, sys_reset=1, pll_ready=0, retry_count=0
  - state=ASSERT_RST (00), counter=RST_CYCLES-1
- pll_locked passes through a 2-flop synchronizer. lk_s is the second flop, reset to 0. All decisions use lk_s, so synchronizer latency is 2 cycles.
- States:
  - ASSERT_RST (00):
    - Outputs: pll_rst=1, sys_reset=1.
    - Counter decrements each cycle. At 0 → WAIT_LOCK, load counter=LOCK_TIMEOUT-1.
    - pll_rst is therefore high exactly RST_CYCLES cycles.
  - WAIT_LOCK (01):
    - Outputs: pll_rst=0, sys_reset=1.
    - lk_s=1 → STABLE, load counter=STABLE_CYCLES-1.
    - Else counter=0 → ASSERT_RST, retry_count+1 (saturates at 255), load counter=RST_CYCLES-1.
    - Else decrement.
    - If lk_s=1 and counter=0 in the same cycle, lock wins → STABLE.
  - STABLE (10):
    - Outputs: pll_rst=0, sys_reset=1.
    - lk_s=0 → WAIT_LOCK, reload counter=LOCK_TIMEOUT-1. This is a glitch during qualification; no retry increment.
    - Else counter=0 → RUN.
    - Else decrement.
  - RUN (11):
    - Outputs: pll_rst=0, sys_reset=0, pll_ready=1.
    - lk_s=0 → ASSERT_RST, retry_count+1 (saturating), load counter=RST_CYCLES-1.
    - sys_reset and pll_ready are registered with the state, so they change the same cycle state_dbg changes.
- Release latency from lk_s first high, lock held steady: STABLE_CYCLES+1 cycles in STABLE/transition, then sys_reset falls on entry to RUN.
- Lock loss in RUN:
  - sys_reset reasserts on the cycle after lk_s is sampled low, i.e. 3 clk edges after the pll_locked fall.
  - pll_rst rises on that same cycle.
- Counter never underflows: every transition reloads it; it only decrements while nonzero.
- A reset mid-operation (any state) forces the reset values on the next edge; retry_count clears.
- retry_count at 255 stays 255.
- No combinational path exists from pll_locked to any output.

Test Plan:
- Normal bring-up. Params RST_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=8. Release reset; raise pll_locked 10 cycles after pll_rst falls.
  → pll_rst high exactly 4 cycles.
  → sys_reset falls 2+8+1 cycles after pll_locked rises.
  → pll_ready=1, state_dbg=11, retry_count=0.
- Timeout retry. Same params; pll_locked held 0.
  → pll_rst pulses of 4 cycles every 4+50 cycles.
  → retry_count increments per timeout: 1, 2, 3…
  → sys_reset stays 1 throughout.
- Glitch during qualification. Raise pll_locked, drop it for 3 cycles at STABLE count 5, raise again.
  → FSM returns to WAIT_LOCK with no retry increment.
  → Full 8-cycle stable window restarts; sys_reset released only after an uninterrupted window.
- Lock loss in RUN. From RUN, drop pll_locked.
  → Within 3 edges: sys_reset=1, pll_ready=0, pll_rst=1 for 4 cycles.
  → retry_count+1.
  → Full re-sequence to RUN once lock returns.
- Saturation and reset mid-operation:
  - Force 260 timeouts → retry_count=255, not wrapped.
  - Then assert reset during WAIT_LOCK → next edge shows state_dbg=00, retry_count=0, pll_rst=1, sys_reset=1.
- Boundary. lk_s rises on the exact cycle the WAIT_LOCK counter hits 0.
  → Transition to STABLE; no retry increment; no pll_rst pulse.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for a qualified lock, then
// releases the core's system reset; re-sequences on timeout or lock loss.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       pll_ready,
    output logic [7:0] retry_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ASSERT_RST = 2'b00,
        WAIT_LOCK  = 2'b01,
        STABLE     = 2'b10,
        RUN        = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LD = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic             sync1_q, lk_s_q;
    logic             pll_rst_q, sys_reset_q, pll_ready_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;
        case (state_q)
            ASSERT_RST: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TIMEOUT_LD;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (lk_s_q) begin
                    state_d = STABLE;
                    cnt_d   = STABLE_LD;
                end else if (cnt_q == '0) begin
                    state_d = ASSERT_RST;
                    cnt_d   = RST_LD;
                    retry_d = sat_inc(retry_q);
                end
            end
            STABLE: begin
                if (!lk_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TIMEOUT_LD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lk_s_q) begin
                    state_d = ASSERT_RST;
                    cnt_d   = RST_LD;
                    retry_d = sat_inc(retry_q);
                end
            end
            default: begin
                state_d = ASSERT_RST;
                cnt_d   = RST_LD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            lk_s_q      <= 1'b0;
            state_q     <= ASSERT_RST;
            cnt_q       <= RST_LD;
            retry_q     <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            pll_ready_q <= 1'b0;
        end else begin
            sync1_q     <= pll_locked;
            lk_s_q      <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            // Output flops follow the next state so they switch with state_dbg.
            pll_rst_q   <= (state_d == ASSERT_RST);
            sys_reset_q <= (state_d != RUN);
            pll_ready_q <= (state_d == RUN);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset   = sys_reset_q;
    assign pll_ready   = pll_ready_q;
    assign retry_count = retry_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=50,
// STABLE_CYCLES=8; expected latencies and counts are hand-computed.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       pll_ready;
    logic [7:0] retry_count;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;
    bit sr_low_seen;
    int n;

    pll_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (50),
        .STABLE_CYCLES(8),
        .CNT_W        (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_reset  (sys_reset),
        .pll_ready  (pll_ready),
        .retry_count(retry_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and sample 1 time unit after each edge.
    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (!sys_reset) sr_low_seen = 1'b1;
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return sys_reset;
            default: return 1'b0;
        endcase
    endfunction

    // Count edges until the selected output reaches val (bounded).
    task automatic edges_until(input int sel, input logic val, input int max, output int cnt);
        cnt = 0;
        do begin
            tick(1);
            cnt++;
        end while (sig(sel) !== val && cnt < max);
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s, input int max);
        int k;
        k = 0;
        while (state_dbg !== s && k < max) begin
            tick(1);
            k++;
        end
        chk(tag, {30'd0, state_dbg}, {30'd0, s});
    endtask

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;
        tick(3);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);
        chk("rst_pll_rst", {31'd0, pll_rst}, 32'd1);
        chk("rst_sys_reset", {31'd0, sys_reset}, 32'd1);
        chk("rst_ready", {31'd0, pll_ready}, 32'd0);
        chk("rst_retry", {24'd0, retry_count}, 32'd0);

        // Normal bring-up
        reset = 1'b0;
        edges_until(0, 1'b0, 100, n);
        chk("bringup_rst_len", n, 32'd4);
        chk("bringup_wait_state", {30'd0, state_dbg}, 32'd1);
        tick(10);
        pll_locked = 1'b1;
        edges_until(1, 1'b0, 200, n);
        chk("bringup_release_lat", n, 32'd11);
        chk("bringup_state", {30'd0, state_dbg}, 32'd3);
        chk("bringup_ready", {31'd0, pll_ready}, 32'd1);
        chk("bringup_pll_rst", {31'd0, pll_rst}, 32'd0);
        chk("bringup_retry", {24'd0, retry_count}, 32'd0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        tick(2);
        chk("loss_edge2_sysrst", {31'd0, sys_reset}, 32'd0);
        tick(1);
        chk("loss_sysrst", {31'd0, sys_reset}, 32'd1);
        chk("loss_ready", {31'd0, pll_ready}, 32'd0);
        chk("loss_pll_rst", {31'd0, pll_rst}, 32'd1);
        chk("loss_state", {30'd0, state_dbg}, 32'd0);
        chk("loss_retry", {24'd0, retry_count}, 32'd1);
        edges_until(0, 1'b0, 100, n);
        chk("loss_rst_len", n, 32'd4);
        pll_locked = 1'b1;
        edges_until(1, 1'b0, 200, n);
        chk("loss_reseq_lat", n, 32'd11);
        chk("loss_reseq_retry", {24'd0, retry_count}, 32'd1);

        // Glitch during qualification
        pll_locked = 1'b0;
        tick(3);
        chk("glitch_prep_retry", {24'd0, retry_count}, 32'd2);
        pll_locked = 1'b1;
        wait_state("glitch_reach_stable", 2'd2, 100);
        tick(2);
        pll_locked = 1'b0;
        tick(3);
        chk("glitch_back_wait", {30'd0, state_dbg}, 32'd1);
        chk("glitch_no_retry", {24'd0, retry_count}, 32'd2);
        pll_locked = 1'b1;
        edges_until(1, 1'b0, 200, n);
        chk("glitch_full_window", n, 32'd11);
        chk("glitch_end_retry", {24'd0, retry_count}, 32'd2);

        // Timeout retry
        pll_locked = 1'b0;
        tick(3);
        chk("to_entry_retry", {24'd0, retry_count}, 32'd3);
        sr_low_seen = 1'b0;
        for (int p = 0; p < 2; p++) begin
            edges_until(0, 1'b0, 100, n);
            chk("to_rst_len", n, 32'd4);
            edges_until(0, 1'b1, 200, n);
            chk("to_wait_len", n, 32'd50);
            chk("to_retry", {24'd0, retry_count}, 32'(4 + p));
        end
        chk("to_sysrst_held", {31'd0, sr_low_seen}, 32'd0);

        // Boundary: lk_s rises on the cycle the WAIT_LOCK counter is 0
        wait_state("bnd_wait", 2'd1, 100);
        tick(47);
        pll_locked = 1'b1;
        tick(2);
        chk("bnd_at_zero_state", {30'd0, state_dbg}, 32'd1);
        tick(1);
        chk("bnd_state", {30'd0, state_dbg}, 32'd2);
        chk("bnd_retry", {24'd0, retry_count}, 32'd5);
        chk("bnd_pll_rst", {31'd0, pll_rst}, 32'd0);
        tick(8);
        chk("bnd_run", {30'd0, state_dbg}, 32'd3);

        // Saturation then reset during WAIT_LOCK
        pll_locked = 1'b0;
        tick(3);
        chk("sat_entry_retry", {24'd0, retry_count}, 32'd6);
        tick(54 * 260);
        chk("sat_retry", {24'd0, retry_count}, 32'd255);
        wait_state("sat_wait", 2'd1, 100);
        tick(5);
        reset = 1'b1;
        tick(1);
        chk("midrst_state", {30'd0, state_dbg}, 32'd0);
        chk("midrst_retry", {24'd0, retry_count}, 32'd0);
        chk("midrst_pll_rst", {31'd0, pll_rst}, 32'd1);
        chk("midrst_sys_reset", {31'd0, sys_reset}, 32'd1);
        chk("midrst_ready", {31'd0, pll_ready}, 32'd0);
        reset = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
